pipe_wb_regfile: RTL and testbench
==================================

Name: pipe_wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: takes wwreg, wm2reg, wmo, walu, wrn from the MEM/WB register.
- Selects the writeback data (memory load result or ALU result) and commits it to the architectural register file.
- Provides two asynchronous read ports to the ID stage.
- Exposes the selected writeback data for forwarding, plus a retired-write counter for performance monitoring.

Parameters:
- DW, 32, data width of registers and writeback buses
- AW, 5, register-number width
- NREG, 32, number of architectural registers (must equal 2**AW)
- CW, 32, width of retired-write counter

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- clrn  in  1  asynchronous active-low reset
- wwreg  in  1  WB stage writes a register this cycle
- wm2reg  in  1  1 = write wmo (load data), 0 = write walu
- wmo  in  DW  memory read data from MEM/WB
- walu  in  DW  ALU result from MEM/WB
- wrn  in  AW  destination register number
- rna  in  AW  read port A register number (ID stage rs)
- rnb  in  AW  read port B register number (ID stage rt)
- qa  out  DW  read port A data
- qb  out  DW  read port B data
- wdi  out  DW  selected writeback data (combinational), for the forwarding network
- wcount  out  CW  number of committed non-r0 writes since reset

Behaviour:
- Asynchronous reset: clrn=0 immediately clears all registers 1..NREG-1 to 0 and wcount to 0, so qa/qb read 0.
- Reset asserted mid-cycle overrides any pending write. The first write is possible at the first posedge after clrn rises.
- Writeback mux: wdi = wm2reg ? wmo : walu. It is purely combinational and valid regardless of wwreg.
- Write: at posedge clk, if clrn=1, wwreg=1 and wrn!=0, then reg[wrn] <= wdi. Exactly one write port.
- Register r0 is hardwired to 0:
  - writes to wrn=0 are discarded;
  - reads of r0 always return 0;
  - writes to r0 do not increment wcount.
- Read ports are combinational: qa = reg[rna], qb = reg[rnb], with r0 returning 0.
  - rna==rnb is legal; both ports return the same value.
- wcount increments by 1 on each committed write.
  - It saturates at 2**CW-1 (no wrap).
  - It is held otherwise.
- No X on outputs after reset. Inputs with wwreg=0 have no effect on state.
- Single-cycle latency: data written at edge N is visible on qa/qb after edge N.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: same-cycle write-through bypass.
  - If wwreg=1, wrn!=0 and wrn==rna, then qa=wdi combinationally in the same cycle as the write; likewise for qb/rnb.
  - The ID stage may read a value being written back without an extra stall.
- Not defined: qa/qb return the stored value only.
  - A same-cycle read of wrn returns the old contents.
  - The hazard unit must stall one additional cycle for a WB-to-ID dependence.
- wcount and write behaviour are identical in both builds.

Decomposition:
- Shared package holds:
  - DW/AW/NREG constants;
  - the register-number typedef;
  - the R0 constant (zero register number);
  - the wm2reg encoding constants (SEL_ALU=0, SEL_MEM=1), also used by the ID-stage control unit.
- One sub-module, wb_mux: the wm2reg 2:1 writeback selector, reused by the forwarding path.
- Register array, read logic, bypass and counter stay in pipe_wb_regfile.

Test Plan:
- Reset mid-operation:
  - Write r5=32'h1234_5678, then pulse clrn=0 between edges.
  - Require: qa with rna=5 reads 0 immediately, and wcount=0.
- Writeback select:
  - wwreg=1, wrn=3, walu=32'hAAAA_0001, wmo=32'h5555_0002, wm2reg=0, one edge → r3=32'hAAAA_0001.
  - Repeat with wm2reg=1 → r3=32'h5555_0002.
  - wdi tracks the mux in both cases.
- r0 protection:
  - wwreg=1, wrn=0, walu=32'hFFFF_FFFF → qa with rna=0 stays 0 and wcount is unchanged.
- wwreg gating:
  - wwreg=0, wrn=7, walu=32'hDEAD_BEEF for 3 edges → r7 unchanged (0) and wcount unchanged.
- Same-cycle read-during-write:
  - r9=32'h11, then wwreg=1, wrn=9, walu=32'h22, rna=rnb=9 before the edge.
  - With WB_BYPASS_EN: qa=qb=32'h22 pre-edge.
  - Without WB_BYPASS_EN: qa=qb=32'h11 pre-edge, 32'h22 post-edge.
- Counter:
  - 31 writes to r1..r31 → wcount=31, and each register reads back its written value.
  - Force the counter near its maximum (CW=4 build), 20 writes → wcount saturates at 15.

Source files
------------

// File: rtl/pipe_wb_regfile_pkg.sv
// Shared constants and types for the writeback stage and register file.
// Also holds the wm2reg select encoding used by the ID-stage control unit.
package pipe_wb_regfile_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef logic [AW-1:0] regno_t;

  localparam regno_t R0 = regno_t'(0);

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/pipe_wb_regfile_wb_mux.sv
// Writeback data selector: load data or ALU result, chosen by wm2reg.
// Purely combinational so the forwarding network can reuse it.
module wb_mux
  import pipe_wb_regfile_pkg::*;
#(
  parameter int unsigned DW = pipe_wb_regfile_pkg::DW
) (
  input  logic          sel,
  input  logic [DW-1:0] alu,
  input  logic [DW-1:0] mem,
  output logic [DW-1:0] y
);

  assign y = (sel == SEL_MEM) ? mem : alu;

endmodule

// File: rtl/pipe_wb_regfile.sv
// WB stage: writeback select, architectural register file with two async
// read ports, and a saturating retired-write counter. Optional same-cycle
// write-through bypass on the read ports is enabled by defining WB_BYPASS_EN.
module pipe_wb_regfile
  import pipe_wb_regfile_pkg::*;
#(
  parameter int unsigned DW   = pipe_wb_regfile_pkg::DW,
  parameter int unsigned AW   = pipe_wb_regfile_pkg::AW,
  parameter int unsigned NREG = pipe_wb_regfile_pkg::NREG,
  parameter int unsigned CW   = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          wwreg,
  input  logic          wm2reg,
  input  logic [DW-1:0] wmo,
  input  logic [DW-1:0] walu,
  input  logic [AW-1:0] wrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [DW-1:0] wdi,
  output logic [CW-1:0] wcount
);

  logic [DW-1:0] regs [NREG];
  logic          we;
  logic [DW-1:0] qa_stored;
  logic [DW-1:0] qb_stored;

  wb_mux #(.DW(DW)) u_wb_mux (
    .sel (wm2reg),
    .alu (walu),
    .mem (wmo),
    .y   (wdi)
  );

  // A write to r0 is not a committed write: no state change, no count.
  assign we = wwreg && (wrn != AW'(R0));

  // Entry 0 is only ever cleared, so it is a constant zero after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < int'(NREG); i++) begin
        if (we && (wrn == AW'(i))) begin
          regs[i] <= wdi;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wcount <= '0;
    end else if (we && (wcount != {CW{1'b1}})) begin
      wcount <= wcount + CW'(1);
    end
  end

  always_comb begin
    qa_stored = '0;
    qb_stored = '0;
    if (rna != AW'(R0)) qa_stored = regs[rna];
    if (rnb != AW'(R0)) qb_stored = regs[rnb];
  end

`ifdef WB_BYPASS_EN
  // Write-through lets ID consume a value in the same cycle it is written back.
  always_comb begin
    qa = qa_stored;
    qb = qb_stored;
    if (we && (wrn == rna)) qa = wdi;
    if (we && (wrn == rnb)) qb = wdi;
  end
`else
  always_comb begin
    qa = qa_stored;
    qb = qb_stored;
  end
`endif

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Self-checking bench for pipe_wb_regfile against an array-based reference model.
module tb_pipe_wb_regfile;

  logic        clk;
  logic        clrn;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] qa, qb, wdi;
  logic [31:0] wcount;
  logic [31:0] qa4, qb4, wdi4;
  logic [3:0]  wcount4;

  int checks;
  int failures;

  logic [31:0] mdl [32];
  int unsigned cnt;
  int unsigned cnt4;

  pipe_wb_regfile dut (
    .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
    .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .wdi(wdi), .wcount(wcount)
  );

  pipe_wb_regfile #(.CW(4)) dut4 (
    .clk(clk), .clrn(clrn), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
    .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb), .qa(qa4), .qb(qb4),
    .wdi(wdi4), .wcount(wcount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    cnt  = 0;
    cnt4 = 0;
  endtask

  // Advance one clock edge and apply the architectural effect of the inputs.
  task automatic tick();
    logic [31:0] d;
    logic        c;
    logic [4:0]  r;
    d = wm2reg ? wmo : walu;
    r = wrn;
    c = wwreg && (wrn != 5'd0) && clrn;
    @(posedge clk);
    #1;
    if (c) begin
      mdl[r] = d;
      cnt++;
      if (cnt4 < 15) cnt4++;
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] rn);
    logic [31:0] v;
    v = (rn == 5'd0) ? 32'h0 : mdl[rn];
`ifdef WB_BYPASS_EN
    if (wwreg && (wrn != 5'd0) && (wrn == rn)) v = wm2reg ? wmo : walu;
`endif
    return v;
  endfunction

  task automatic idle_inputs();
    wwreg = 1'b0; wm2reg = 1'b0; wmo = '0; walu = '0; wrn = '0; rna = '0; rnb = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clrn = 1'b0;
    #12;
    model_reset();
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clrn = 1'b0;
    model_reset();
    #7;
    for (int i = 0; i < 4; i++) begin
      rna = 5'(i * 7 + 1);
      rnb = 5'(31 - i);
      #1;
      checks++;
      if (qa !== 32'h0 || qb !== 32'h0) begin
        failures++;
        $display("FAIL reset_read rn=%0d/%0d got qa=%h qb=%h need 0", rna, rnb, qa, qb);
      end
    end
    checks++;
    if (wcount !== 32'h0 || wcount4 !== 4'h0) begin
      failures++;
      $display("FAIL reset_wcount got %h/%h need 0", wcount, wcount4);
    end
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wb_select();
    logic [31:0] exp_v [2];
    exp_v[0] = 32'hAAAA_0001;
    exp_v[1] = 32'h5555_0002;
    for (int s = 0; s < 2; s++) begin
      wwreg = 1'b1; wrn = 5'd3; walu = 32'hAAAA_0001; wmo = 32'h5555_0002;
      wm2reg = 1'(s); rna = 5'd3; rnb = 5'd0;
      #1;
      checks++;
      if (wdi !== exp_v[s]) begin
        failures++;
        $display("FAIL wdi_sel sel=%0d got %h need %h", s, wdi, exp_v[s]);
      end
      tick();
      wwreg = 1'b0;
      #1;
      checks++;
      if (qa !== exp_v[s]) begin
        failures++;
        $display("FAIL wb_select sel=%0d got r3=%h need %h", s, qa, exp_v[s]);
      end
    end
  endtask

  task automatic test_r0();
    logic [31:0] c0;
    c0 = wcount;
    wwreg = 1'b1; wrn = 5'd0; walu = 32'hFFFF_FFFF; wm2reg = 1'b0; rna = 5'd0; rnb = 5'd0;
    #1;
    checks++;
    if (qa !== 32'h0) begin
      failures++;
      $display("FAIL r0_pre got %h need 0", qa);
    end
    tick();
    wwreg = 1'b0;
    #1;
    checks++;
    if (qa !== 32'h0 || qb !== 32'h0 || wcount !== 32'(cnt) || wcount != c0) begin
      failures++;
      $display("FAIL r0_write got q=%h/%h wcount=%0d need 0/0 wcount=%0d", qa, qb, wcount, cnt);
    end
  endtask

  task automatic test_gating();
    wwreg = 1'b0; wrn = 5'd7; walu = 32'hDEAD_BEEF; wmo = 32'hDEAD_BEEF; rna = 5'd7; rnb = 5'd7;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (qa !== 32'h0 || qb !== 32'h0 || wcount !== 32'(cnt)) begin
      failures++;
      $display("FAIL wwreg_gating got r7=%h wcount=%0d need 0 wcount=%0d", qa, wcount, cnt);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] pre_exp;
    wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'd9; walu = 32'h11;
    tick();
    wwreg = 1'b1; wrn = 5'd9; walu = 32'h22; rna = 5'd9; rnb = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    pre_exp = 32'h22;
`else
    pre_exp = 32'h11;
`endif
    checks++;
    if (qa !== pre_exp || qb !== pre_exp) begin
      failures++;
      $display("FAIL rdw_pre got qa=%h qb=%h need %h", qa, qb, pre_exp);
    end
    tick();
    wwreg = 1'b0;
    #1;
    checks++;
    if (qa !== 32'h22 || qb !== 32'h22) begin
      failures++;
      $display("FAIL rdw_post got qa=%h qb=%h need 00000022", qa, qb);
    end
  endtask

  task automatic test_reset_mid();
    wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'd5; walu = 32'h1234_5678; rna = 5'd5; rnb = 5'd5;
    tick();
    wwreg = 1'b0;
    #1;
    checks++;
    if (qa !== 32'h1234_5678) begin
      failures++;
      $display("FAIL pre_reset_r5 got %h need 12345678", qa);
    end
    wwreg = 1'b1; walu = 32'hCAFE_F00D;
    #1;
    clrn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (qa !== 32'h0 || wcount !== 32'h0 || wcount4 !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset got r5=%h wcount=%0d need 0 0", qa, wcount);
    end
    // Hold reset across an edge with a write pending; the write must be lost.
    tick();
    checks++;
    if (qa !== 32'h0 || wcount !== 32'h0) begin
      failures++;
      $display("FAIL reset_override got r5=%h wcount=%0d need 0 0", qa, wcount);
    end
    clrn = 1'b1;
    #2;
    tick();
    wwreg = 1'b0;
    #1;
    checks++;
    if (qa !== 32'hCAFE_F00D || wcount !== 32'd1) begin
      failures++;
      $display("FAIL first_write got r5=%h wcount=%0d need cafef00d 1", qa, wcount);
    end
  endtask

  task automatic test_counter();
    do_reset();
    for (int i = 1; i < 32; i++) begin
      wwreg = 1'b1; wm2reg = 1'($urandom_range(1)); wmo = $urandom; walu = $urandom; wrn = 5'(i);
      tick();
    end
    wwreg = 1'b0;
    checks++;
    if (wcount !== 32'd31 || wcount4 !== 4'd15) begin
      failures++;
      $display("FAIL count31 got %0d/%0d need 31/15", wcount, wcount4);
    end
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i); rnb = 5'(31 - i);
      #1;
      checks++;
      if (qa !== exp_rd(rna) || qb !== exp_rd(rnb)) begin
        failures++;
        $display("FAIL readback r%0d/r%0d got %h/%h need %h/%h", rna, rnb, qa, qb, exp_rd(rna), exp_rd(rnb));
      end
    end
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      wwreg = 1'b1; wm2reg = 1'b0; walu = $urandom; wrn = 5'($urandom_range(31, 1));
      tick();
      if (k == 14 || k == 15 || k == 20) begin
        checks++;
        if (wcount4 !== 4'(cnt4) || wcount !== 32'(cnt)) begin
          failures++;
          $display("FAIL count_sat k=%0d got %0d/%0d need %0d/%0d", k, wcount4, wcount, cnt4, cnt);
        end
      end
    end
    wwreg = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      wwreg = 1'($urandom_range(3) != 0); wm2reg = 1'($urandom_range(1));
      wmo = $urandom; walu = $urandom; wrn = 5'($urandom_range(31));
      rna = ($urandom_range(3) == 0) ? wrn : 5'($urandom_range(31));
      rnb = ($urandom_range(3) == 0) ? rna : 5'($urandom_range(31));
      #1;
      checks++;
      if (qa !== exp_rd(rna) || qb !== exp_rd(rnb) || qa4 !== exp_rd(rna) || qb4 !== exp_rd(rnb)
          || wdi !== (wm2reg ? wmo : walu) || wdi4 !== wdi || wcount !== 32'(cnt) || wcount4 !== 4'(cnt4)) begin
        failures++;
        $display("FAIL random n=%0d rna=%0d rnb=%0d got qa=%h qb=%h wdi=%h wc=%0d need qa=%h qb=%h wc=%0d",
                 n, rna, rnb, qa, qb, wdi, wcount, exp_rd(rna), exp_rd(rnb), cnt);
      end
      tick();
    end
    wwreg = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    clrn = 1'b0;
    test_reset();
    test_wb_select();
    test_r0();
    test_gating();
    test_read_during_write();
    test_reset_mid();
    test_counter();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
